sdram_arb: RTL and testbench



---
 rtl/sdram_arb.sv | 130 +++++++++++++
 tb/tb_sdram_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb.sv
// sdram_arb: two-port arbiter and sequencer in front of the single SDRAM
// command port. Port 0 serves the CPU (ROM/RAM fetches) and port 1 serves a
// secondary master (loader/DMA). The controller grants one request at a time
// and latches the winner's command onto the M_* side. It holds that command
// until M_DONE, then returns read data and a one-cycle ACK to the winner.
// A starvation counter limits how many consecutive port-0 grants may pass
// while port 1 is waiting.
//
// Ports:
//   clk_cpu, reset             clock, synchronous active-high reset
//   Px_REQ/WE/ADDR/DIN/BE      request level and command fields of port x
//   Px_ACK, Px_DOUT            completion pulse and read data of port x
//   M_REQ/WE/ADDR/DIN/BE       latched command toward the SDRAM controller
//   M_DONE, M_DOUT             completion pulse and read data from SDRAM
//   BUSY                       high whenever the sequencer is not idle
//   OWNER                      port of the current or last grant
module sdram_arb #(
  parameter int AW           = 25,
  parameter int DW           = 32,
  parameter int BW           = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_cpu,
  input  logic          reset,
  input  logic          P0_REQ,
  input  logic          P0_WE,
  input  logic [AW-1:0] P0_ADDR,
  input  logic [DW-1:0] P0_DIN,
  input  logic [BW-1:0] P0_BE,
  output logic          P0_ACK,
  output logic [DW-1:0] P0_DOUT,
  input  logic          P1_REQ,
  input  logic          P1_WE,
  input  logic [AW-1:0] P1_ADDR,
  input  logic [DW-1:0] P1_DIN,
  input  logic [BW-1:0] P1_BE,
  output logic          P1_ACK,
  output logic [DW-1:0] P1_DOUT,
  output logic          M_REQ,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_DIN,
  output logic [BW-1:0] M_BE,
  input  logic          M_DONE,
  input  logic [DW-1:0] M_DOUT,
  output logic          BUSY,
  output logic          OWNER
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // The counter needs at least one bit, even when STARVE_LIMIT is 0.
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          grant1;

  // Port 1 wins when it is the only requester. It also wins a tie once
  // port 0 has used up its allowance. A limit of 0 makes port 1 win every tie.
  always_comb begin
    grant1 = 1'b0;
    if (P1_REQ && (!P0_REQ || (starve_cnt >= LIMIT)))
      grant1 = 1'b1;
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      P0_ACK     <= 1'b0;
      P1_ACK     <= 1'b0;
      P0_DOUT    <= '0;
      P1_DOUT    <= '0;
      M_REQ      <= 1'b0;
      M_WE       <= 1'b0;
      M_ADDR     <= '0;
      M_DIN      <= '0;
      M_BE       <= '0;
      BUSY       <= 1'b0;
      OWNER      <= 1'b0;
    end else begin
      P0_ACK <= 1'b0;
      P1_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (P0_REQ || P1_REQ) begin
            OWNER  <= grant1;
            M_REQ  <= 1'b1;
            M_WE   <= grant1 ? P1_WE   : P0_WE;
            M_ADDR <= grant1 ? P1_ADDR : P0_ADDR;
            M_DIN  <= grant1 ? P1_DIN  : P0_DIN;
            M_BE   <= grant1 ? P1_BE   : P0_BE;
            BUSY   <= 1'b1;
            state  <= ISSUE;
            // Only port-0 grants made while port 1 waits count toward starvation.
            if (grant1 || !P1_REQ)
              starve_cnt <= '0;
            else if (starve_cnt < LIMIT)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ISSUE: begin
          // The command fields stay frozen here. Only M_DONE moves the sequencer on.
          if (M_DONE) begin
            M_REQ <= 1'b0;
            if (!M_WE) begin
              if (OWNER) P1_DOUT <= M_DOUT;
              else       P0_DOUT <= M_DOUT;
            end
            if (OWNER) P1_ACK <= 1'b1;
            else       P0_ACK <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          M_REQ <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
module tb_sdram_arb;
  localparam int AW = 25, DW = 32, BW = 4;
  localparam int LIM_A = 4, LIM_B = 0;

  logic clk_cpu = 1'b0;
  logic reset;
  always #5 clk_cpu = ~clk_cpu;

  logic          P0_REQ, P0_WE, P1_REQ, P1_WE, M_DONE;
  logic [AW-1:0] P0_ADDR, P1_ADDR;
  logic [DW-1:0] P0_DIN, P1_DIN, M_DOUT;
  logic [BW-1:0] P0_BE, P1_BE;
  logic          P0_ACK, P1_ACK, M_REQ, M_WE, BUSY, OWNER;
  logic [DW-1:0] P0_DOUT, P1_DOUT, M_DIN;
  logic [AW-1:0] M_ADDR;
  logic [BW-1:0] M_BE;

  // Second instance with absolute port-1 priority. It shares every input
  // except the request lines and runs in lockstep only during contention.
  logic          P0_REQ_b, P1_REQ_b;
  logic          P0_ACK_b, P1_ACK_b, M_REQ_b, M_WE_b, BUSY_b, OWNER_b;
  logic [DW-1:0] P0_DOUT_b, P1_DOUT_b, M_DIN_b;
  logic [AW-1:0] M_ADDR_b;
  logic [BW-1:0] M_BE_b;

  sdram_arb #(.AW(AW), .DW(DW), .BW(BW), .STARVE_LIMIT(LIM_A)) dut (
    .clk_cpu(clk_cpu), .reset(reset),
    .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_DIN(P0_DIN), .P0_BE(P0_BE),
    .P0_ACK(P0_ACK), .P0_DOUT(P0_DOUT),
    .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_DIN(P1_DIN), .P1_BE(P1_BE),
    .P1_ACK(P1_ACK), .P1_DOUT(P1_DOUT),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_BE(M_BE),
    .M_DONE(M_DONE), .M_DOUT(M_DOUT), .BUSY(BUSY), .OWNER(OWNER));

  sdram_arb #(.AW(AW), .DW(DW), .BW(BW), .STARVE_LIMIT(LIM_B)) dut_b (
    .clk_cpu(clk_cpu), .reset(reset),
    .P0_REQ(P0_REQ_b), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_DIN(P0_DIN), .P0_BE(P0_BE),
    .P0_ACK(P0_ACK_b), .P0_DOUT(P0_DOUT_b),
    .P1_REQ(P1_REQ_b), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_DIN(P1_DIN), .P1_BE(P1_BE),
    .P1_ACK(P1_ACK_b), .P1_DOUT(P1_DOUT_b),
    .M_REQ(M_REQ_b), .M_WE(M_WE_b), .M_ADDR(M_ADDR_b), .M_DIN(M_DIN_b), .M_BE(M_BE_b),
    .M_DONE(M_DONE), .M_DOUT(M_DOUT), .BUSY(BUSY_b), .OWNER(OWNER_b));

  int checks = 0;
  int errors = 0;

  // Reference model: one starvation count per instance and the expected DOUT of each port.
  int            starve_a = 0, starve_b = 0;
  logic [DW-1:0] exp_dout [2];
  logic [DW-1:0] exp_dout_b [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic rand_fields(input int p);
    if (p == 0) begin
      P0_WE = 1'($urandom_range(0, 1)); P0_ADDR = AW'($urandom);
      P0_DIN = $urandom; P0_BE = BW'($urandom);
    end else begin
      P1_WE = 1'($urandom_range(0, 1)); P1_ADDR = AW'($urandom);
      P1_DIN = $urandom; P1_BE = BW'($urandom);
    end
  endtask

  // The tie-break rule. Below the limit, port 0 wins. At the limit, port 1 wins.
  function automatic int pick(input bit r0, input bit r1, input int cnt, input int lim);
    if (r0 && r1) return (cnt >= lim) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  function automatic int next_cnt(input int w, input bit r1, input int cnt, input int lim);
    if (w == 1 || !r1) return 0;
    return (cnt < lim) ? cnt + 1 : lim;
  endfunction

  // One transaction. It starts in an IDLE cycle with the requests already
  // driven and ends in the next IDLE cycle. M_DONE is asserted in cycle
  // 'delay' counted from the first M_REQ cycle.
  task automatic run_txn(input int delay, input logic [DW-1:0] rdata,
                         input bit hold, input bit scramble, input bit with_b);
    int w, wb;
    logic we, we_b;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [BW-1:0] be;
    w    = pick(P0_REQ, P1_REQ, starve_a, LIM_A);
    wb   = pick(P0_REQ_b, P1_REQ_b, starve_b, LIM_B);
    we   = (w == 1) ? P1_WE : P0_WE;
    addr = (w == 1) ? P1_ADDR : P0_ADDR;
    din  = (w == 1) ? P1_DIN : P0_DIN;
    be   = (w == 1) ? P1_BE : P0_BE;
    we_b = (wb == 1) ? P1_WE : P0_WE;
    starve_a = next_cnt(w, P1_REQ, starve_a, LIM_A);
    if (with_b) starve_b = next_cnt(wb, P1_REQ_b, starve_b, LIM_B);
    tick();
    check("grant_owner", OWNER, w);
    check("grant_busy", BUSY, 1);
    if (with_b) begin
      check("b_owner", OWNER_b, wb);
      check("b_m_req", M_REQ_b, 1);
      check("b_m_we", M_WE_b, we_b);
      check("b_m_addr", M_ADDR_b, (wb == 1) ? P1_ADDR : P0_ADDR);
      check("b_m_din", M_DIN_b, (wb == 1) ? P1_DIN : P0_DIN);
      check("b_m_be", M_BE_b, (wb == 1) ? P1_BE : P0_BE);
      check("b_busy", BUSY_b, 1);
    end
    if (scramble) begin
      if (w == 1) begin P1_ADDR = ~P1_ADDR; P1_DIN = ~P1_DIN; P1_BE = ~P1_BE; P1_WE = ~P1_WE; end
      else        begin P0_ADDR = ~P0_ADDR; P0_DIN = ~P0_DIN; P0_BE = ~P0_BE; P0_WE = ~P0_WE; end
    end
    for (int i = 1; i <= delay; i++) begin
      check("hold_m_req", M_REQ, 1);
      check("hold_m_we", M_WE, we);
      check("hold_m_addr", M_ADDR, addr);
      check("hold_m_din", M_DIN, din);
      check("hold_m_be", M_BE, be);
      check("hold_busy", BUSY, 1);
      check("hold_ack0", P0_ACK, 0);
      check("hold_ack1", P1_ACK, 0);
      if (i < delay) tick();
    end
    M_DONE = 1'b1;
    M_DOUT = rdata;
    tick();
    M_DONE = 1'b0;
    M_DOUT = $urandom;
    if (!we) exp_dout[w] = rdata;
    if (with_b && !we_b) exp_dout_b[wb] = rdata;
    check("resp_ack0", P0_ACK, (w == 0));
    check("resp_ack1", P1_ACK, (w == 1));
    check("resp_dout0", P0_DOUT, exp_dout[0]);
    check("resp_dout1", P1_DOUT, exp_dout[1]);
    check("resp_m_req", M_REQ, 0);
    check("resp_busy", BUSY, 1);
    if (with_b) begin
      check("b_resp_ack0", P0_ACK_b, (wb == 0));
      check("b_resp_ack1", P1_ACK_b, (wb == 1));
      check("b_resp_dout0", P0_DOUT_b, exp_dout_b[0]);
      check("b_resp_dout1", P1_DOUT_b, exp_dout_b[1]);
    end
    if (!hold) begin
      if (w == 1) P1_REQ = 1'b0; else P0_REQ = 1'b0;
    end
    tick();
    check("idle_busy", BUSY, 0);
    check("idle_ack0", P0_ACK, 0);
    check("idle_ack1", P1_ACK, 0);
    check("idle_m_req", M_REQ, 0);
  endtask

  initial begin
    reset = 1'b1;
    P0_REQ = 0; P1_REQ = 0; P0_REQ_b = 0; P1_REQ_b = 0; M_DONE = 0; M_DOUT = '0;
    P0_WE = 0; P1_WE = 0; P0_ADDR = '0; P1_ADDR = '0; P0_DIN = '0; P1_DIN = '0;
    P0_BE = '0; P1_BE = '0;
    exp_dout[0] = '0; exp_dout[1] = '0; exp_dout_b[0] = '0; exp_dout_b[1] = '0;
    tick(); tick();
    check("rst_m_req", M_REQ, 0);
    check("rst_busy", BUSY, 0);
    check("rst_owner", OWNER, 0);
    check("rst_acks", {P0_ACK, P1_ACK}, 0);
    check("rst_douts", {P0_DOUT, P1_DOUT}, 0);
    check("rst_m_fields", {M_WE, M_ADDR, M_DIN, M_BE}, 0);
    reset = 1'b0;
    tick();

    // Single P0 read with a one-cycle memory.
    P0_REQ = 1; P0_WE = 0; P0_ADDR = 25'h0001000; P0_DIN = '0; P0_BE = 4'hF;
    run_txn(1, 32'hDEADBEEF, 0, 0, 0);
    check("t1_dout0", P0_DOUT, 32'hDEADBEEF);

    // P1 write with partial byte enables. DOUT must stay unchanged.
    P1_REQ = 1; P1_WE = 1; P1_ADDR = 25'h0000ABC; P1_DIN = 32'h12345678; P1_BE = 4'b0011;
    run_txn(2, 32'hCAFEF00D, 0, 0, 0);
    check("t2_dout1", P1_DOUT, 32'h0);

    // Continuous contention: order 0,0,0,0,1 for limit 4, always 1 for limit 0.
    P0_WE = 0; P0_ADDR = 25'h100; P0_DIN = 32'h1; P0_BE = 4'h1;
    P1_WE = 0; P1_ADDR = 25'h200; P1_DIN = 32'h2; P1_BE = 4'h2;
    P0_REQ = 1; P1_REQ = 1; P0_REQ_b = 1; P1_REQ_b = 1;
    for (int k = 0; k < 10; k++) begin
      run_txn($urandom_range(1, 3), $urandom, 1, 0, 1);
      check("order_a", OWNER, (k % 5 == 4));
      check("order_b", OWNER_b, 1);
    end
    P0_REQ = 0; P1_REQ = 0; P0_REQ_b = 0; P1_REQ_b = 0;
    tick();

    // Spurious M_DONE while idle is ignored.
    M_DONE = 1; M_DOUT = 32'h55AA55AA;
    tick();
    M_DONE = 0;
    check("spur_acks", {P0_ACK, P1_ACK}, 0);
    check("spur_busy", BUSY, 0);
    check("spur_m_req", M_REQ, 0);
    check("spur_dout0", P0_DOUT, exp_dout[0]);
    tick();
    check("spur_acks2", {P0_ACK, P1_ACK}, 0);

    // Requester changes its fields after the grant.
    rand_fields(0); P0_REQ = 1;
    run_txn(3, $urandom, 0, 1, 0);

    // Slow memory.
    rand_fields(0); P0_REQ = 1;
    run_txn(20, $urandom, 0, 0, 0);

    // Push the starve count up, then reset during ISSUE.
    P0_WE = 0; P1_WE = 0; P0_REQ = 1; P1_REQ = 1;
    for (int k = 0; k < 3; k++) run_txn(1, $urandom, 1, 0, 0);
    tick();
    check("mid_owner", OWNER, 0);
    check("mid_m_req", M_REQ, 1);
    tick();
    reset = 1;
    tick();
    reset = 0; P0_REQ = 0; P1_REQ = 0;
    M_DONE = 1; M_DOUT = 32'h0BADF00D;
    check("rstmid_m_req", M_REQ, 0);
    check("rstmid_busy", BUSY, 0);
    check("rstmid_acks", {P0_ACK, P1_ACK}, 0);
    check("rstmid_owner", OWNER, 0);
    check("rstmid_douts", {P0_DOUT, P1_DOUT}, 0);
    tick();
    M_DONE = 0;
    check("rstmid_acks2", {P0_ACK, P1_ACK}, 0);
    check("rstmid_busy2", BUSY, 0);
    check("rstmid_m_req2", M_REQ, 0);
    starve_a = 0; starve_b = 0;
    exp_dout[0] = '0; exp_dout[1] = '0; exp_dout_b[0] = '0; exp_dout_b[1] = '0;
    // A cleared counter lets port 0 win the next tie.
    rand_fields(0); rand_fields(1); P0_REQ = 1; P1_REQ = 1;
    run_txn(1, $urandom, 0, 0, 0);
    check("post_rst_owner", OWNER, 0);
    run_txn(2, $urandom, 0, 0, 0);
    check("post_rst_owner2", OWNER, 1);

    // Randomised traffic. The loser keeps its request and fields stable.
    for (int n = 0; n < 60; n++) begin
      if (!P0_REQ && $urandom_range(0, 1) == 1) begin rand_fields(0); P0_REQ = 1; end
      if (!P1_REQ && $urandom_range(0, 1) == 1) begin rand_fields(1); P1_REQ = 1; end
      if (!P0_REQ && !P1_REQ) begin
        if ($urandom_range(0, 1) == 1) begin rand_fields(1); P1_REQ = 1; end
        else begin rand_fields(0); P0_REQ = 1; end
      end
      run_txn($urandom_range(1, 5), $urandom, 0, ($urandom_range(0, 3) == 0), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
